// File: rtl/key_reader.sv
// Debounced push-button reader: per-key 2-flop synchronizer, debounce FSM and
// auto-repeat timer producing registered level, press, release and strobe outputs.
module key_reader #(
    parameter int NKEYS           = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000,
    parameter int REPEAT_EN       = 1,
    parameter int CNT_W           = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NKEYS-1:0] key_n,
    output logic [NKEYS-1:0] key_state,
    output logic [NKEYS-1:0] key_press,
    output logic [NKEYS-1:0] key_release,
    output logic [NKEYS-1:0] key_strobe
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS_WAIT,
        S_HELD,
        S_REPEAT,
        S_RELEASE_WAIT
    } key_fsm_e;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [NKEYS-1:0] sync1, sync2, raw;

    // Sync flops reset to the released level so reset never looks like a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    assign raw = ~sync2;

    for (genvar i = 0; i < NKEYS; i++) begin : g_key
        key_fsm_e         state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             press_d, release_d, strobe_d;
        logic             state_r, press_r, release_r, strobe_r;

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            strobe_d  = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (raw[i]) begin
                        state_d = S_PRESS_WAIT;
                        cnt_d   = '0;
                    end
                end
                S_PRESS_WAIT: begin
                    if (!raw[i]) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_d  = S_HELD;
                        cnt_d    = '0;
                        press_d  = 1'b1;
                        strobe_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_HELD: begin
                    if (!raw[i]) begin
                        state_d = S_RELEASE_WAIT;
                        cnt_d   = '0;
                    end else if (REPEAT_EN == 0) begin
                        cnt_d = '0;
                    end else if (cnt_q == RD_LAST) begin
                        state_d  = S_REPEAT;
                        cnt_d    = '0;
                        strobe_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_REPEAT: begin
                    if (!raw[i]) begin
                        state_d = S_RELEASE_WAIT;
                        cnt_d   = '0;
                    end else if (cnt_q == RP_LAST) begin
                        cnt_d    = '0;
                        strobe_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_RELEASE_WAIT: begin
                    // A bounce back to pressed restarts the full repeat delay.
                    if (raw[i]) begin
                        state_d = S_HELD;
                        cnt_d   = '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_d   = S_IDLE;
                        cnt_d     = '0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q   <= S_IDLE;
                cnt_q     <= '0;
                state_r   <= 1'b0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
                strobe_r  <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                state_r   <= (state_d == S_HELD) || (state_d == S_REPEAT) ||
                             (state_d == S_RELEASE_WAIT);
                press_r   <= press_d;
                release_r <= release_d;
                strobe_r  <= strobe_d;
            end
        end

        assign key_state[i]   = state_r;
        assign key_press[i]   = press_r;
        assign key_release[i] = release_r;
        assign key_strobe[i]  = strobe_r;
    end

endmodule

// File: tb/tb_key_reader.sv
// Randomized and directed bench for key_reader against a run-length debounce
// model with an age-based repeat schedule, scored through an expected queue.
module tb_key_reader;

    localparam int NK = 2;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;
    localparam int W  = 5 * NK;

    logic          clk;
    logic          rst;
    logic [NK-1:0] key_n;
    logic [NK-1:0] key_state, key_press, key_release, key_strobe;
    logic [NK-1:0] state_nr, press_nr, release_nr, strobe_nr;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int ns;
    int c0;
    int n_rel;
    int hold [NK];

    // model state
    logic [NK-1:0] m_s1, m_s2, m_smp, m_lvl;
    logic [NK-1:0] e_press, e_rel, e_strb;
    int            m_run [NK];
    int            m_age [NK];
    logic [W-1:0]  exp_q [$];
    logic [W-1:0]  e;

    key_reader #(
        .NKEYS(NK), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP), .REPEAT_EN(1), .CNT_W(4)
    ) u_dut (
        .clk(clk), .rst(rst), .key_n(key_n),
        .key_state(key_state), .key_press(key_press),
        .key_release(key_release), .key_strobe(key_strobe)
    );

    key_reader #(
        .NKEYS(NK), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP), .REPEAT_EN(0), .CNT_W(4)
    ) u_dut_norep (
        .clk(clk), .rst(rst), .key_n(key_n),
        .key_state(state_nr), .key_press(press_nr),
        .key_release(release_nr), .key_strobe(strobe_nr)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, expv);
        end
    endtask

    // Reference: a change is accepted after DB+1 consecutive opposing samples;
    // repeat strobes fall at hold ages RD, RD+RP, RD+2RP, ...
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            m_s1 = '1;
            m_s2 = '1;
            m_lvl = '0;
            e_press = '0;
            e_rel = '0;
            e_strb = '0;
            for (int k = 0; k < NK; k++) begin
                m_run[k] = 0;
                m_age[k] = 0;
            end
        end else begin
            m_smp = ~m_s2;
            m_s2 = m_s1;
            m_s1 = key_n;
            e_press = '0;
            e_rel = '0;
            e_strb = '0;
            for (int k = 0; k < NK; k++) begin
                if (m_smp[k] != m_lvl[k]) begin
                    m_run[k]++;
                    if (m_run[k] == DB + 1) begin
                        m_lvl[k] = m_smp[k];
                        m_run[k] = 0;
                        if (m_lvl[k]) begin
                            e_press[k] = 1'b1;
                            e_strb[k] = 1'b1;
                            m_age[k] = 0;
                        end else begin
                            e_rel[k] = 1'b1;
                        end
                    end
                end else if (m_run[k] > 0) begin
                    m_run[k] = 0;
                    m_age[k] = 0;
                end else if (m_lvl[k]) begin
                    m_age[k]++;
                    if (m_age[k] == RD || (m_age[k] > RD && (m_age[k] - RD) % RP == 0))
                        e_strb[k] = 1'b1;
                end
            end
        end
        exp_q.push_back({m_lvl, e_press, e_rel, e_strb, e_press});
    end

    // scoreboard
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("key_state",    {30'd0, key_state},   {30'd0, e[9:8]});
            check("key_press",    {30'd0, key_press},   {30'd0, e[7:6]});
            check("key_release",  {30'd0, key_release}, {30'd0, e[5:4]});
            check("key_strobe",   {30'd0, key_strobe},  {30'd0, e[3:2]});
            check("strobe_norep", {30'd0, strobe_nr},   {30'd0, e[1:0]});
            check("state_norep",  {30'd0, state_nr},    {30'd0, e[9:8]});
        end
    end

    // driver tasks
    task automatic wait_pulse(input int k, input bit rel, input int start, input string tag);
        int lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((rel ? key_release[k] : key_press[k]) === 1'b1) begin
                lat = cyc - start;
                break;
            end
        end
        check(tag, lat, DB + 2);
    endtask

    task automatic drive_and_measure(input int k, input logic lvl_n, input string tag);
        int start;
        @(negedge clk);
        key_n[k] = lvl_n;
        start = cyc + 1;
        wait_pulse(k, (lvl_n == 1'b1), start, tag);
    endtask

    initial begin
        rst = 1'b1;
        key_n = '1;
        repeat (3) @(negedge clk);
        check("reset_outputs", {24'd0, key_state, key_press, key_release, key_strobe}, 32'd0);
        rst = 1'b0;

        // clean press / release on key 0
        drive_and_measure(0, 1'b0, "press_latency");
        repeat (3) @(negedge clk);
        drive_and_measure(0, 1'b1, "release_latency");
        repeat (4) @(negedge clk);

        // bounce, then held press and auto-repeat count over 30 cycles
        repeat (10) begin
            key_n[0] = 1'b0;
            repeat (3) @(negedge clk);
            key_n[0] = 1'b1;
            @(negedge clk);
        end
        drive_and_measure(0, 1'b0, "bounce_then_press");
        ns = int'(key_strobe[0]);
        repeat (29) begin
            @(negedge clk);
            ns += int'(key_strobe[0]);
        end
        check("repeat_strobe_count", ns, 8);

        // release bounce while repeating
        key_n[0] = 1'b1;
        repeat (2) @(negedge clk);
        key_n[0] = 1'b0;
        n_rel = 0;
        repeat (20) begin
            @(negedge clk);
            n_rel += int'(key_release[0]);
        end
        check("release_bounce", n_rel, 0);

        // reset with key 0 repeating and key 1 mid press-debounce
        key_n[1] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("reset_mid_outputs", {24'd0, key_state, key_press, key_release, key_strobe}, 32'd0);
        c0 = cyc + 1;
        wait_pulse(0, 1'b0, c0, "repress_after_reset");
        repeat (5) @(negedge clk);
        key_n = '1;
        repeat (12) @(negedge clk);

        // simultaneous press on both keys
        key_n = '0;
        c0 = cyc + 1;
        wait_pulse(0, 1'b0, c0, "simul_latency");
        check("simul_press", {30'd0, key_press}, 32'd3);
        repeat (20) @(negedge clk);
        key_n = '1;
        repeat (12) @(negedge clk);

        // randomized run lengths with occasional reset
        for (int k = 0; k < NK; k++) hold[k] = 0;
        repeat (3000) begin
            @(negedge clk);
            rst = ($urandom_range(0, 499) == 0);
            for (int k = 0; k < NK; k++) begin
                if (hold[k] == 0) begin
                    key_n[k] = ~key_n[k];
                    hold[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4)
                                                         : $urandom_range(5, 40);
                end else begin
                    hold[k]--;
                end
            end
        end
        rst = 1'b0;
        key_n = '1;
        repeat (15) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
